d_ext_pipe: RTL and testbench
=============================

// Module: d_ext_pipe
// PURPOSE
//  Parametrised decode-stage immediate generator with a registered, elastic output.
//  Extends a 16-bit immediate or a 26-bit jump field to XLEN bits under a 3-bit mode,
//  including branch-target and jump-target arithmetic.
//  Sits between the D-stage decoder and the D/E boundary; a 2-entry skid buffer gives
//  full throughput under E-stage backpressure. Supports flush on branch mispredict or exception.
// PARAMETERS
//  XLEN    32  datapath width; must satisfy XLEN >= 2*IMM_W and XLEN > JIMM_W+2
//  IMM_W   16  I-type immediate width
//  JIMM_W  26  J-type index width
//  TAG_W   5   sideband tag width (destination register number), passed through unchanged
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  flush      in   1       synchronous flush; clears all held entries
//  in_valid   in   1       input beat valid
//  in_ready   out  1       unit can accept a beat this cycle
//  ext_op     in   3       mode; encodings in d_ext_pkg
//  imm_in     in   IMM_W   I-type immediate
//  jimm_in    in   JIMM_W  J-type index
//  pc_in      in   XLEN    PC of the instruction
//  tag_in     in   TAG_W   sideband tag
//  out_valid  out  1       output beat valid
//  out_ready  in   1       consumer accepts the beat this cycle
//  imm_out    out  XLEN    extended result
//  tag_out    out  TAG_W   tag of the beat on imm_out
//  op_err     out  1       beat on imm_out used a reserved ext_op; qualified by out_valid
// BEHAVIOUR
//  ext_op modes; pc4 = pc_in + 4, wraps mod 2^XLEN:
//   000 ZERO -> 0
//   001 ZEXT -> zero-extend imm_in
//   010 SEXT -> sign-extend imm_in
//   011 LUI  -> imm_in << (XLEN-IMM_W), low bits 0
//   100 BOFF -> SEXT << 2
//   101 BTGT -> pc4 + (SEXT << 2), wraps mod 2^XLEN
//   110 JTGT -> {pc4[XLEN-1:JIMM_W+2], jimm_in, 2'b00}
//   111 reserved -> result 0, op_err=1
//  Result is computed combinationally from the inputs and captured at the input handshake.
//  Latency: 1 cycle from in_valid&&in_ready to out_valid.
//  Storage: main register M (drives outputs) and skid register S.
//   - in_ready = !S.valid (registered flag, no combinational path from out_ready).
//   - Accepting while M is full and not draining (!out_ready) writes S.
//   - When M drains and S is full, S moves to M; S.valid clears.
//   - Simultaneous accept and drain with S empty: new beat goes to M with no bubble.
//  Ordering: beats leave in acceptance order; no beat is dropped or duplicated.
//  Consumer contract: while out_valid && !out_ready, imm_out, tag_out and op_err hold stable.
//  flush=1: M.valid and S.valid are 0 next cycle; a beat offered in the flush cycle is
//   discarded; in_ready=1 next cycle. flush has priority over every other event.
//  Reset (async assert, sync release): out_valid=0, imm_out=0, tag_out=0, op_err=0,
//   S.valid=0, in_ready=1. Reset asserted mid-transfer loses all held beats.
//  Datapath bits in M and S need no reset beyond the values listed above.
// STRUCTURE
//  d_ext_pkg: localparams EXT_ZERO..EXT_RSVD (3-bit), EXT_OP_W=3.
//  Sub-module d_ext_core: purely combinational {ext_op, imm_in, jimm_in, pc_in}
//   -> {result, err}; same parameters. d_ext_pipe holds only the skid and handshake logic.
// TESTING (XLEN=32)
//  1. ZEXT 0x8001 -> 0x00008001; SEXT 0x8001 -> 0xFFFF8001; LUI 0x1234 -> 0x12340000;
//     each appears 1 cycle after its handshake.
//  2. BTGT pc=0x00003000, imm=0xFFFF -> 0x00003000; pc=0xFFFFFFFC, imm=0x0001 -> 0x00000004 (wrap).
//  3. JTGT pc=0x80000000, jimm=0x0000010 -> 0x80000040; ext_op=111 -> imm_out=0, op_err=1.
//  4. Backpressure: stream 5 beats, out_ready=0 for 3 cycles -> in_ready drops after 2 held,
//     outputs stay stable, all 5 tags exit in order with no gaps once out_ready=1.
//  5. flush with M and S both full plus in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     no stale beat ever emitted.
//  6. reset_n pulled low asynchronously mid-stream -> out_valid=0 immediately; after release,
//     first accepted beat appears 1 cycle later.

Source files
------------

// File: rtl/d_ext_pkg.sv
// Shared encodings for the decode-stage immediate generator.
package d_ext_pkg;

  localparam int unsigned EXT_OP_W = 3;

  localparam logic [EXT_OP_W-1:0] EXT_ZERO = 3'b000;
  localparam logic [EXT_OP_W-1:0] EXT_ZEXT = 3'b001;
  localparam logic [EXT_OP_W-1:0] EXT_SEXT = 3'b010;
  localparam logic [EXT_OP_W-1:0] EXT_LUI  = 3'b011;
  localparam logic [EXT_OP_W-1:0] EXT_BOFF = 3'b100;
  localparam logic [EXT_OP_W-1:0] EXT_BTGT = 3'b101;
  localparam logic [EXT_OP_W-1:0] EXT_JTGT = 3'b110;
  localparam logic [EXT_OP_W-1:0] EXT_RSVD = 3'b111;

endpackage

// File: rtl/d_ext_core.sv
// Combinational immediate extension plus branch/jump target arithmetic.
module d_ext_core
  import d_ext_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIMM_W = 26
) (
  input  logic [EXT_OP_W-1:0] ext_op,
  input  logic [IMM_W-1:0]    imm_in,
  input  logic [JIMM_W-1:0]   jimm_in,
  input  logic [XLEN-1:0]     pc_in,
  output logic [XLEN-1:0]     result,
  output logic                err
);

  logic [XLEN-1:0] zext;
  logic [XLEN-1:0] sext;
  logic [XLEN-1:0] lui;
  logic [XLEN-1:0] boff;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] btgt;
  logic [XLEN-1:0] jtgt;

  assign zext = {{(XLEN-IMM_W){1'b0}}, imm_in};
  assign sext = {{(XLEN-IMM_W){imm_in[IMM_W-1]}}, imm_in};
  assign lui  = {imm_in, {(XLEN-IMM_W){1'b0}}};
  assign boff = sext << 2;
  assign pc4  = pc_in + XLEN'(4);
  assign btgt = pc4 + boff;
  // Jump keeps the region bits of the sequential PC above the index field.
  assign jtgt = {pc4[XLEN-1:JIMM_W+2], jimm_in, 2'b00};

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (ext_op)
      EXT_ZERO: result = '0;
      EXT_ZEXT: result = zext;
      EXT_SEXT: result = sext;
      EXT_LUI:  result = lui;
      EXT_BOFF: result = boff;
      EXT_BTGT: result = btgt;
      EXT_JTGT: result = jtgt;
      default:  err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/d_ext_pipe.sv
// Immediate generator with a registered, 2-entry skid-buffered output stage.
module d_ext_pipe
  import d_ext_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIMM_W = 26,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXT_OP_W-1:0] ext_op,
  input  logic [IMM_W-1:0]    imm_in,
  input  logic [JIMM_W-1:0]   jimm_in,
  input  logic [XLEN-1:0]     pc_in,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     imm_out,
  output logic [TAG_W-1:0]    tag_out,
  output logic                op_err
);

  logic [XLEN-1:0]  core_res;
  logic             core_err;
  logic             accept;

  logic             m_valid_q, m_valid_d;
  logic [XLEN-1:0]  m_imm_q,   m_imm_d;
  logic [TAG_W-1:0] m_tag_q,   m_tag_d;
  logic             m_err_q,   m_err_d;
  logic             s_valid_q, s_valid_d;
  logic [XLEN-1:0]  s_imm_q,   s_imm_d;
  logic [TAG_W-1:0] s_tag_q,   s_tag_d;
  logic             s_err_q,   s_err_d;

  d_ext_core #(
    .XLEN   (XLEN),
    .IMM_W  (IMM_W),
    .JIMM_W (JIMM_W)
  ) u_core (
    .ext_op  (ext_op),
    .imm_in  (imm_in),
    .jimm_in (jimm_in),
    .pc_in   (pc_in),
    .result  (core_res),
    .err     (core_err)
  );

  assign accept = in_valid && !s_valid_q;

  // M loads when empty or draining; S catches a beat only while M is stalled.
  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_tag_d   = m_tag_q;
    m_err_d   = m_err_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_tag_d   = s_tag_q;
    s_err_d   = s_err_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_ready) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = s_imm_q;
        m_tag_d   = s_tag_q;
        m_err_d   = s_err_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_imm_d   = core_res;
        m_tag_d   = tag_in;
        m_err_d   = core_err;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_imm_d   = core_res;
      s_tag_d   = tag_in;
      s_err_d   = core_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_tag_q   <= '0;
      m_err_q   <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_tag_q   <= m_tag_d;
      m_err_q   <= m_err_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Skid payload is only meaningful while s_valid_q is set.
  always_ff @(posedge clk) begin
    s_imm_q <= s_imm_d;
    s_tag_q <= s_tag_d;
    s_err_q <= s_err_d;
  end

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign imm_out   = m_imm_q;
  assign tag_out   = m_tag_q;
  assign op_err    = m_err_q;

endmodule

// File: tb/tb_d_ext_pipe.sv
// Scoreboard bench for d_ext_pipe at XLEN=32.
module tb_d_ext_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ext_op;
  logic [15:0] imm_in;
  logic [25:0] jimm_in;
  logic [31:0] pc_in;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_out;
  logic [4:0]  tag_out;
  logic        op_err;

  d_ext_pipe #(.XLEN(32), .IMM_W(16), .JIMM_W(26), .TAG_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ext_op    (ext_op),
    .imm_in    (imm_in),
    .jimm_in   (jimm_in),
    .pc_in     (pc_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .tag_out   (tag_out),
    .op_err    (op_err)
  );

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_mode = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on each output handshake, checks hold stability.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_imm;
  logic [4:0]  prev_tag;
  logic        prev_err;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_tests++;
        if (out_valid !== 1'b1 || imm_out !== prev_imm || tag_out !== prev_tag || op_err !== prev_err) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%b imm=%h tag=%0d err=%b, expected v=1 imm=%h tag=%0d err=%b",
                   out_valid, imm_out, tag_out, op_err, prev_imm, prev_tag, prev_err);
        end
      end
      if (out_valid === 1'b1 && out_ready && !flush) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got imm=%h tag=%0d, expected no beat", imm_out, tag_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (imm_out !== e.imm || tag_out !== e.tag || op_err !== e.err) begin
            n_fail++;
            $display("FAIL beat_data: got imm=%h tag=%0d err=%b, expected imm=%h tag=%0d err=%b",
                     imm_out, tag_out, op_err, e.imm, e.tag, e.err);
          end
          if (e.chk_lat) begin
            n_tests++;
            if (cyc != e.acc_cyc + 1) begin
              n_fail++;
              $display("FAIL latency tag=%0d: got %0d cycles, expected 1", e.tag, cyc - e.acc_cyc);
            end
          end
          pop_cyc.push_back(cyc);
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_imm  = imm_out;
      prev_tag  = tag_out;
      prev_err  = op_err;
    end
  end

  function automatic void model(input logic [2:0] op, input logic [15:0] imm, input logic [25:0] jimm,
                                input logic [31:0] pc, output logic [31:0] r, output logic e);
    logic [31:0] s;
    logic [31:0] p4;
    s  = {{16{imm[15]}}, imm};
    p4 = pc + 32'd4;
    e  = 1'b0;
    case (op)
      3'd0: r = 32'h0;
      3'd1: r = {16'h0, imm};
      3'd2: r = s;
      3'd3: r = {imm, 16'h0};
      3'd4: r = {s[29:0], 2'b00};
      3'd5: r = p4 + {s[29:0], 2'b00};
      3'd6: r = {p4[31:28], jimm, 2'b00};
      default: begin r = 32'h0; e = 1'b1; end
    endcase
  endfunction

  task automatic send(input logic [2:0] op, input logic [15:0] imm, input logic [25:0] jimm,
                      input logic [31:0] pc, input logic [4:0] tag,
                      input logic [31:0] eimm, input logic eerr);
    bit   got;
    exp_t e;
    got      = 1'b0;
    in_valid = 1'b1;
    ext_op   = op;
    imm_in   = imm;
    jimm_in  = jimm;
    pc_in    = pc;
    tag_in   = tag;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.imm = eimm; e.tag = tag; e.err = eerr; e.acc_cyc = cyc; e.chk_lat = lat_mode;
        sb.push_back(e);
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout tag=%0d: got in_ready=0 for 50 cycles, expected acceptance", tag);
    end
  endtask

  task automatic send_rand(input logic [4:0] tag);
    logic [2:0]  op;
    logic [15:0] imm;
    logic [25:0] jimm;
    logic [31:0] pc;
    logic [31:0] r;
    logic        e;
    op   = 3'($urandom_range(0, 7));
    imm  = 16'($urandom);
    jimm = 26'($urandom);
    pc   = {$urandom} & 32'hFFFF_FFFC;
    model(op, imm, jimm, pc, r, e);
    send(op, imm, jimm, pc, tag, r, e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ext_op = 3'd0; imm_in = '0; jimm_in = '0; pc_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_out !== 32'h0 || tag_out !== 5'd0 || op_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b imm=%h tag=%0d err=%b, expected v=0 rdy=1 imm=0 tag=0 err=0",
               out_valid, in_ready, imm_out, tag_out, op_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    lat_mode = 1'b1; out_ready = 1'b1;
    send(3'b001, 16'h8001, 26'h0, 32'h0,         5'd1, 32'h0000_8001, 1'b0);
    send(3'b010, 16'h8001, 26'h0, 32'h0,         5'd2, 32'hFFFF_8001, 1'b0);
    send(3'b011, 16'h1234, 26'h0, 32'h0,         5'd3, 32'h1234_0000, 1'b0);
    send(3'b101, 16'hFFFF, 26'h0, 32'h0000_3000, 5'd4, 32'h0000_3000, 1'b0);
    send(3'b101, 16'h0001, 26'h0, 32'hFFFF_FFFC, 5'd5, 32'h0000_0004, 1'b0);
    send(3'b110, 16'h0,    26'h10, 32'h8000_0000, 5'd6, 32'h8000_0040, 1'b0);
    send(3'b111, 16'hABCD, 26'h3, 32'h1234_5678, 5'd7, 32'h0000_0000, 1'b1);
    send(3'b000, 16'hFFFF, 26'h0, 32'h0,         5'd8, 32'h0000_0000, 1'b0);
    send(3'b100, 16'h8000, 26'h0, 32'h0,         5'd9, 32'hFFFE_0000, 1'b0);
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    lat_mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_rand(5'(i + 10));
    idle();
    wait_drain();
  endtask

  task automatic test_backpressure();
    lat_mode = 1'b0; out_ready = 1'b0;
    pop_cyc.delete();
    send_rand(5'd10);
    send_rand(5'd11);
    ext_op = 3'd1; imm_in = 16'h00C0; tag_in = 5'd12; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag_out !== 5'd10) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got rdy=%b v=%b tag=%0d, expected rdy=0 v=1 tag=10",
                 i, in_ready, out_valid, tag_out);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd1, 16'h00C0, 26'h0, 32'h0, 5'd12, 32'h0000_00C0, 1'b0);
    send_rand(5'd13);
    send_rand(5'd14);
    idle();
    wait_drain();
    n_tests++;
    if (pop_cyc.size() != 5) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats, expected 5", pop_cyc.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        n_tests++;
        if (pop_cyc[k] != pop_cyc[0] + k) begin
          n_fail++;
          $display("FAIL bp_gap beat%0d: got cycle offset %0d, expected %0d", k, pop_cyc[k] - pop_cyc[0], k);
        end
      end
    end
  endtask

  task automatic test_flush();
    lat_mode = 1'b0; out_ready = 1'b0;
    send_rand(5'd20);
    send_rand(5'd21);
    in_valid = 1'b1; tag_in = 5'd22; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lat_mode = 1'b1;
    send_rand(5'd23);
    idle();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    lat_mode = 1'b0; out_ready = 1'b0;
    send_rand(5'd30);
    send_rand(5'd31);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
    end
    sb.delete();
    idle();
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1; lat_mode = 1'b1;
    send(3'b011, 16'hBEEF, 26'h0, 32'h0, 5'd3, 32'hBEEF_0000, 1'b0);
    idle();
    wait_drain();
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
